// File: rtl/arithmetic_unit.sv
// Registered add/sub/mul (one cycle) and restoring divide (DATA_W cycles) behind a start/busy/done handshake.
// Optional macro ARITHMETIC_UNIT_REMAINDER_EN: divide result carries {remainder, quotient}, else zero-extended quotient.
module arithmetic_unit #(
   parameter int DATA_W = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [1:0]            operation,
   input  logic [DATA_W-1:0]     A,
   input  logic [DATA_W-1:0]     B,
   output logic [2*DATA_W-1:0]   result,
   output logic                  error,
   output logic                  busy,
   output logic                  done
);

   localparam int RW    = 2 * DATA_W;
   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

   logic [DATA_W-1:0] rem;
   logic [DATA_W-1:0] quo;
   logic [DATA_W-1:0] dvs;
   logic [CNT_W-1:0]  cnt;

   logic [RW-1:0]     ext_a;
   logic [RW-1:0]     ext_b;
   logic [RW-1:0]     op_res;
   logic [DATA_W:0]   rem_sh;
   logic [DATA_W:0]   diff;
   logic [DATA_W-1:0] rem_n;
   logic [DATA_W-1:0] quo_n;
   logic [RW-1:0]     div_res;

   always_comb begin
      ext_a = {{DATA_W{1'b0}}, A};
      ext_b = {{DATA_W{1'b0}}, B};
      op_res = '0;
      case (operation)
         2'b00:   op_res = ext_a + ext_b;
         2'b01:   op_res = ext_a - ext_b;
         2'b10:   op_res = ext_a * ext_b;
         default: op_res = '0;
      endcase
   end

   // One restoring step: shift next dividend bit in, keep the subtraction only if it did not borrow.
   always_comb begin
      rem_sh = {rem, quo[DATA_W-1]};
      diff   = rem_sh - {1'b0, dvs};
      if (!diff[DATA_W]) begin
         rem_n = diff[DATA_W-1:0];
         quo_n = {quo[DATA_W-2:0], 1'b1};
      end else begin
         rem_n = rem_sh[DATA_W-1:0];
         quo_n = {quo[DATA_W-2:0], 1'b0};
      end
`ifdef ARITHMETIC_UNIT_REMAINDER_EN
      div_res = {rem_n, quo_n};
`else
      div_res = {{DATA_W{1'b0}}, quo_n};
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result <= '0;
         error  <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         rem    <= '0;
         quo    <= '0;
         dvs    <= '0;
         cnt    <= '0;
      end else begin
         done <= 1'b0;
         if (busy) begin
            rem <= rem_n;
            quo <= quo_n;
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST) begin
               busy   <= 1'b0;
               done   <= 1'b1;
               result <= div_res;
               error  <= 1'b0;
            end
         end else if (start) begin
            if (operation == 2'b11 && B != '0) begin
               busy <= 1'b1;
               rem  <= '0;
               quo  <= A;
               dvs  <= B;
               cnt  <= '0;
            end else if (operation == 2'b11) begin
               result <= '0;
               error  <= 1'b1;
               done   <= 1'b1;
            end else begin
               result <= op_res;
               error  <= 1'b0;
               done   <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_arithmetic_unit.sv
// Scoreboard bench for arithmetic_unit: directed vectors push expected {result,error}; a negedge monitor pops on done.
module tb_arithmetic_unit;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [1:0] operation;
   logic [3:0] A;
   logic [3:0] B;
   logic [7:0] result;
   logic       error;
   logic       busy;
   logic       done;

   int n_vec  = 0;
   int n_fail = 0;

   logic [8:0] exp_q[$];

   arithmetic_unit #(.DATA_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .operation(operation),
      .A(A), .B(B), .result(result), .error(error), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef ARITHMETIC_UNIT_REMAINDER_EN
   localparam logic [7:0] EXP_7_2  = 8'h13;
   localparam logic [7:0] EXP_13_3 = 8'h14;
   localparam logic [7:0] EXP_3_5  = 8'h30;
`else
   localparam logic [7:0] EXP_7_2  = 8'h03;
   localparam logic [7:0] EXP_13_3 = 8'h04;
   localparam logic [7:0] EXP_3_5  = 8'h00;
`endif

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected_done: got result %0h error %0b, expected no completion", result, error);
         end else begin
            logic [8:0] e;
            e = exp_q.pop_front();
            check("result", {24'h0, result}, {24'h0, e[7:0]});
            check("error", {31'h0, error}, {31'h0, e[8]});
         end
      end
   end

   task automatic issue(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
      @(negedge clk);
      start     = 1'b1;
      operation = op;
      A         = a;
      B         = b;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         start = 1'b0;
         A     = $urandom_range(15);
         B     = $urandom_range(15);
      end
   endtask

   // Issue one op, count busy cycles seen at negedges, optionally poke an ignored start mid-divide.
   task automatic run_op(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [7:0] exp_res, input logic exp_err, input int exp_busy,
                         input bit poke, input string name);
      int cnt;
      int guard;
      exp_q.push_back({exp_err, exp_res});
      issue(op, a, b);
      @(negedge clk);
      start = 1'b0;
      A     = 4'hF;
      B     = 4'hF;
      cnt   = 0;
      guard = 0;
      while (busy && guard < 20) begin
         cnt++;
         guard++;
         if (poke && cnt == 1) begin
            start = 1'b1; operation = 2'b00; A = 4'd3; B = 4'd5;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      check({name, "_busy_cycles"}, cnt, exp_busy);
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; operation = 2'b00; A = 4'h0; B = 4'h0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_result", {24'h0, result}, 32'h0);
      check("reset_flags", {29'h0, error, busy, done}, 32'h0);

      run_op(2'b00, 4'd3, 4'd5, 8'h08, 1'b0, 0, 1'b0, "add_3_5");
      run_op(2'b00, 4'd15, 4'd15, 8'h1E, 1'b0, 0, 1'b0, "add_15_15");
      run_op(2'b01, 4'd6, 4'd3, 8'h03, 1'b0, 0, 1'b0, "sub_6_3");
      run_op(2'b01, 4'd3, 4'd6, 8'hFD, 1'b0, 0, 1'b0, "sub_3_6");
      run_op(2'b10, 4'd3, 4'd2, 8'h06, 1'b0, 0, 1'b0, "mul_3_2");
      run_op(2'b10, 4'd15, 4'd15, 8'hE1, 1'b0, 0, 1'b0, "mul_15_15");
      run_op(2'b11, 4'd8, 4'd2, 8'h04, 1'b0, 4, 1'b0, "div_8_2");
      run_op(2'b11, 4'd7, 4'd2, EXP_7_2, 1'b0, 4, 1'b0, "div_7_2");
      run_op(2'b11, 4'd13, 4'd3, EXP_13_3, 1'b0, 4, 1'b0, "div_13_3");
      run_op(2'b11, 4'd3, 4'd5, EXP_3_5, 1'b0, 4, 1'b0, "div_3_5");
      run_op(2'b11, 4'd15, 4'd1, 8'h0F, 1'b0, 4, 1'b0, "div_15_1");
      run_op(2'b11, 4'd8, 4'd0, 8'h00, 1'b1, 0, 1'b0, "div_by_zero");
      run_op(2'b00, 4'd3, 4'd5, 8'h08, 1'b0, 0, 1'b0, "add_clears_err");

      // start while busy must be dropped, not queued
      run_op(2'b11, 4'd7, 4'd2, EXP_7_2, 1'b0, 4, 1'b1, "div_ignored_start");
      idle(4);
      check("hold_result", {24'h0, result}, {24'h0, EXP_7_2});
      check("idle_done", {31'h0, done}, 32'h0);

      // back-to-back non-divide starts keep done high
      exp_q.push_back({1'b0, 8'h0A});
      issue(2'b00, 4'd4, 4'd6);
      exp_q.push_back({1'b0, 8'h0C});
      issue(2'b10, 4'd4, 4'd3);
      exp_q.push_back({1'b0, 8'hFF});
      issue(2'b01, 4'd0, 4'd1);
      idle(3);

      // async reset in the middle of a divide
      issue(2'b11, 4'd9, 4'd2);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_result", {24'h0, result}, 32'h0);
      check("abort_flags", {29'h0, error, busy, done}, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      idle(8);
      check("post_abort_result", {24'h0, result}, 32'h0);
      check("post_abort_busy", {31'h0, busy}, 32'h0);
      check("scoreboard_empty", exp_q.size(), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
